// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, hazard-unit controls and MEM/WB forwarding
// sources in, ALU operands and pipeline controls out. The DUT side is the slave modport.
interface id_ex_stage_if #(
    parameter int N = 32
);
    logic         stall;
    logic         flush;
    logic         id_valid;
    logic [N-1:0] id_rs_data;
    logic [N-1:0] id_rt_data;
    logic [15:0]  id_imm;
    logic [4:0]   id_shamt;
    logic [4:0]   id_rs;
    logic [4:0]   id_rt;
    logic [4:0]   id_rd;
    logic [5:0]   id_opcode;
    logic [5:0]   id_funct;
    logic [1:0]   id_alu_op;
    logic         id_alu_src;
    logic         id_reg_write;
    logic         id_reg_dst;

    logic         mem_reg_write;
    logic [4:0]   mem_rd;
    logic [N-1:0] mem_result;
    logic         wb_reg_write;
    logic [4:0]   wb_rd;
    logic [N-1:0] wb_result;

    logic [N-1:0] alu_input1;
    logic [N-1:0] alu_input2;
    logic [5:0]   alu_operation;
    logic         ex_valid;
    logic         ex_reg_write;
    logic [4:0]   ex_dest;
    logic         ex_illegal;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_rd, id_opcode, id_funct, id_alu_op, id_alu_src,
               id_reg_write, id_reg_dst,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        input  alu_input1, alu_input2, alu_operation, ex_valid, ex_reg_write,
               ex_dest, ex_illegal
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_rd, id_opcode, id_funct, id_alu_op, id_alu_src,
               id_reg_write, id_reg_dst,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        output alu_input1, alu_input2, alu_operation, ex_valid, ex_reg_write,
               ex_dest, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU op decode, operand select and optional MEM/WB forwarding.
// Define ID_EX_FORWARD_EN to build the forwarding muxes; otherwise latched register-file values are used.
module id_ex_stage #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    id_ex_stage_if.slave   bus
);
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;

    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_ANDI = 6'b001100;
    localparam logic [5:0] OPC_ORI  = 6'b001101;
    localparam logic [5:0] OPC_XORI = 6'b001110;

    typedef struct packed {
        logic         valid;
        logic         reg_write;
        logic         illegal;
        logic         shift;
        logic         alu_src;
        logic [4:0]   dest;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   shamt;
        logic [5:0]   op;
        logic [N-1:0] rs_data;
        logic [N-1:0] rt_data;
        logic [N-1:0] imm;
    } stage_t;

    function automatic stage_t bubble();
        stage_t b;
        b    = '0;
        b.op = OP_ADD;
        return b;
    endfunction

    if (N < 16) begin : g_width_check
        $error("id_ex_stage: N must be at least 16");
    end

    stage_t       r;
    stage_t       nxt;
    logic [5:0]   dec_op;
    logic         dec_illegal;
    logic         dec_shift;
    logic         imm_zext;
    logic [N-1:0] imm_ext;
    logic [N-1:0] fwd_rs;
    logic [N-1:0] fwd_rt;

    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        case (bus.id_alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (bus.id_funct)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR: dec_op = bus.id_funct;
                    OP_SRL, OP_SRA: begin
                        dec_op    = bus.id_funct;
                        dec_shift = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (bus.id_opcode)
                    OPC_ADDI: dec_op = OP_ADD;
                    OPC_ANDI: dec_op = OP_AND;
                    OPC_ORI:  dec_op = OP_OR;
                    OPC_XORI: dec_op = OP_XOR;
                    default:  dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Logical immediates zero-extend; arithmetic and everything else sign-extend.
    assign imm_zext = (bus.id_opcode == OPC_ANDI) || (bus.id_opcode == OPC_ORI) ||
                      (bus.id_opcode == OPC_XORI);
    assign imm_ext  = imm_zext ? N'(bus.id_imm) : N'($signed(bus.id_imm));

    always_comb begin
        nxt = bubble();
        if (!bus.flush && bus.id_valid) begin
            nxt.valid     = 1'b1;
            nxt.reg_write = bus.id_reg_write & ~dec_illegal;
            nxt.illegal   = dec_illegal;
            nxt.shift     = dec_shift;
            nxt.alu_src   = bus.id_alu_src;
            nxt.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            nxt.rs        = bus.id_rs;
            nxt.rt        = bus.id_rt;
            nxt.shamt     = bus.id_shamt;
            nxt.op        = dec_illegal ? OP_ADD : dec_op;
            nxt.rs_data   = bus.id_rs_data;
            nxt.rt_data   = bus.id_rt_data;
            nxt.imm       = imm_ext;
        end
    end

    // Flush overrides stall, so a bubble lands even while the stage is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= bubble();
        end else if (bus.flush || !bus.stall) begin
            r <= nxt;
        end
    end

`ifdef ID_EX_FORWARD_EN
    function automatic logic [N-1:0] fwd_sel(
        input logic [4:0]   idx,
        input logic [N-1:0] reg_val,
        input logic         m_we,
        input logic [4:0]   m_rd,
        input logic [N-1:0] m_val,
        input logic         w_we,
        input logic [4:0]   w_rd,
        input logic [N-1:0] w_val
    );
        if (m_we && (m_rd == idx) && (idx != 5'd0)) return m_val;
        if (w_we && (w_rd == idx) && (idx != 5'd0)) return w_val;
        return reg_val;
    endfunction

    assign fwd_rs = fwd_sel(r.rs, r.rs_data, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    assign fwd_rt = fwd_sel(r.rt, r.rt_data, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_result);
`else
    logic unused_fwd;

    assign fwd_rs     = r.rs_data;
    assign fwd_rt     = r.rt_data;
    assign unused_fwd = ^{bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_result, r.rs, r.rt};
`endif

    assign bus.alu_input1    = r.shift ? fwd_rt : fwd_rs;
    assign bus.alu_input2    = r.shift   ? N'(r.shamt) :
                               r.alu_src ? r.imm       : fwd_rt;
    assign bus.alu_operation = r.op;
    assign bus.ex_valid      = r.valid;
    assign bus.ex_reg_write  = r.reg_write;
    assign bus.ex_dest       = r.dest;
    assign bus.ex_illegal    = r.illegal;
endmodule
